rr_arb_lock: RTL and testbench
==============================

Name: rr_arb_lock

Overview:
- Sequential round-robin arbiter for a shared single-owner resource, e.g. one datapath port serving several requesters.
- Grants one requester at a time and holds the grant until the owner signals done, or until a hold timeout expires.
- Selection is a parametric priority encode with a rotating start point: the lowest requesting index at or after the priority pointer, wrapping around.
- Sits in front of the shared unit; the one-hot grant and the grant index drive its input muxing.

Parameters:
- nreqs, 4, number of requesters; must be >= 2.
- max_hold, 16, maximum cycles one grant may be held before forced release; must be >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous active-high reset.
- reqs  input  nreqs  request vector; bit i = requester i wants the resource.
- done  input  1  owner releases the resource; sampled only in BUSY.
- grant  output  nreqs  one-hot grant, registered; all zero when no owner.
- grant_idx  output  $clog2(nreqs)  index of the current owner; 0 when no owner.
- grant_val  output  1  high iff grant is nonzero.
- timeout  output  1  one-cycle pulse when a grant is forcibly released.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - state=IDLE, grant=0, grant_idx=0, grant_val=0, timeout=0.
  - Priority pointer ptr=0, hold counter cnt=0.
  - Reset asserted mid-grant drops the grant on the next edge without a timeout pulse.
- Registered state (all outputs are registered, no combinational input-to-output paths):
  - state: IDLE or BUSY.
  - ptr: $clog2(nreqs) bits.
  - cnt: $clog2(max_hold) bits.
- Selection function sel(reqs, ptr):
  - Scan indices ptr, ptr+1, ..., nreqs-1, 0, ..., ptr-1.
  - Return the first index whose reqs bit is 1.
  - Defined only when reqs != 0.
- IDLE:
  - reqs==0: stay in IDLE; all outputs 0.
  - reqs!=0 at edge t: at t+1, state=BUSY, grant_idx=sel, grant=1<<sel, grant_val=1, cnt=0.
  - Latency from request to grant is 1 cycle.
  - done is ignored in IDLE.
- BUSY:
  - Grant is held regardless of reqs. The owner dropping its request does not release it; other requesters are not evaluated.
  - done==1 at edge t: at t+1, state=IDLE, grant=0, grant_val=0, grant_idx=0, ptr=(owner+1) mod nreqs.
  - Earliest next grant is t+2: there is one mandatory idle bubble between grants.
  - done==0 and cnt==max_hold-1: forced release with the same updates as done. timeout=1 for exactly the cycle where grant first reads 0.
  - Otherwise: cnt increments by 1.
  - If done==1 and cnt==max_hold-1 coincide, treat it as a normal done (timeout stays 0).
  - A grant therefore lasts at most max_hold cycles of grant_val=1.
- ptr wrap: owner nreqs-1 sets ptr to 0. ptr changes only on release.
- Invariants:
  - grant is zero or one-hot.
  - grant_val == |grant.
  - grant[grant_idx] == 1 whenever grant_val is high.
  - timeout never coincides with grant_val=1.
- Bits of reqs that change while in BUSY have no effect until IDLE.

Test Plan:
- Reset, then reqs=4'b0000 for 5 cycles -> grant=0, grant_val=0, timeout=0 throughout.
- reqs=4'b1010 from reset (ptr=0) -> next cycle grant=4'b0010, grant_idx=1. Pulse done -> grant=0 next cycle, ptr=2. Keep reqs=4'b1010 -> grant=4'b1000, grant_idx=3 one cycle later.
- reqs=4'b1111 held; each grant is released with done after 2 cycles -> grant_idx sequence is 0,1,2,3,0 with one idle cycle between grants. The wrap from 3 back to 0 is verified.
- reqs=4'b0100, done never asserted, max_hold=16 -> grant_val high exactly 16 cycles. Next cycle grant=0 and timeout=1 for one cycle; timeout is 0 the following cycle; ptr=3. Repeat with done asserted on the 16th cycle -> timeout stays 0.
- While granted to idx 2, drop reqs to 4'b0001 -> grant stays 4'b0100 until done. Afterwards grant=4'b0001.
- Assert reset during BUSY with idx 1 -> next cycle all outputs 0 and ptr=0. Then reqs=4'b0011 -> grant_idx=0.

Source files
------------

// File: rtl/rr_arb_lock.sv
// -----------------------------------------------------------------------------
// rr_arb_lock
//
// Round-robin arbiter in front of a shared resource that has one owner at a
// time. In IDLE it picks the first requester at or after the priority pointer
// (wrapping around) and grants it on the next edge. In BUSY it holds that
// grant, ignoring reqs, until the owner raises done or the hold limit is
// reached. Either kind of release moves the pointer one past the old owner,
// so every requester gets a fair turn. A forced release also raises timeout
// for one cycle. Every output is a register, so no input reaches an output
// without passing through a flop.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset; overrides everything else
//   reqs       request vector, bit i = requester i wants the resource
//   done       owner releases the resource (looked at only in BUSY)
//   grant      one-hot grant, all zero when nobody owns the resource
//   grant_idx  index of the current owner, 0 when nobody owns it
//   grant_val  high iff grant is nonzero
//   timeout    one-cycle pulse on the first idle cycle after a forced release
// -----------------------------------------------------------------------------
module rr_arb_lock #(
  parameter int nreqs    = 4,   // number of requesters, >= 2
  parameter int max_hold = 16   // longest grant in cycles, >= 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [nreqs-1:0]         reqs,
  input  logic                     done,
  output logic [nreqs-1:0]         grant,
  output logic [$clog2(nreqs)-1:0] grant_idx,
  output logic                     grant_val,
  output logic                     timeout
);

  localparam int IW = $clog2(nreqs);
  localparam int CW = $clog2(max_hold);

  typedef logic [IW-1:0] idx_t;
  typedef logic [CW-1:0] cnt_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam idx_t IDX_LAST = idx_t'(nreqs - 1);
  localparam cnt_t CNT_LAST = cnt_t'(max_hold - 1);

  state_t           state, state_nxt;
  idx_t             ptr, ptr_nxt;
  cnt_t             cnt, cnt_nxt;
  logic [nreqs-1:0] grant_nxt;
  idx_t             grant_idx_nxt;
  logic             grant_val_nxt;
  logic             timeout_nxt;

  // Rotating priority encode: walk the indices starting at ptr and wrapping
  // around, and keep the first one that is requesting. sel_found equals
  // |reqs, and sel_idx is meaningful only when sel_found is high.
  logic sel_found;
  idx_t sel_idx;

  always_comb begin
    // NOTE: every variable written in always_comb gets a value before any
    // branch; otherwise a path that skips the assignment infers a latch.
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < nreqs; k++) begin
      if (!sel_found && reqs[(int'(ptr) + k) % nreqs]) begin
        sel_found = 1'b1;
        sel_idx   = idx_t'((int'(ptr) + k) % nreqs);
      end
    end
  end

  // Pointer after a release: one past the owner, and back to 0 after the last.
  idx_t ptr_after_owner;
  assign ptr_after_owner = (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;

  // Next-state and next-output logic. The outputs go to registers here, which
  // keeps them free of glitches and of combinational paths from the inputs.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    cnt_nxt       = cnt;
    grant_nxt     = grant;
    grant_idx_nxt = grant_idx;
    grant_val_nxt = grant_val;
    timeout_nxt   = 1'b0;

    unique case (state)
      IDLE: begin
        // done means nothing here; only a pending request moves us on.
        if (sel_found) begin
          state_nxt          = BUSY;
          grant_nxt          = '0;
          grant_nxt[sel_idx] = 1'b1;
          grant_idx_nxt      = sel_idx;
          grant_val_nxt      = 1'b1;
          cnt_nxt            = '0;
        end
      end

      BUSY: begin
        // cnt counts the grant cycles already used, so at CNT_LAST the owner
        // is in its max_hold-th cycle. When done arrives on that same cycle
        // it counts as a normal release and no timeout is flagged.
        if (done || (cnt == CNT_LAST)) begin
          state_nxt     = IDLE;
          grant_nxt     = '0;
          grant_idx_nxt = '0;
          grant_val_nxt = 1'b0;
          cnt_nxt       = '0;
          ptr_nxt       = ptr_after_owner;
          timeout_nxt   = !done;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      default: begin
        state_nxt     = IDLE;
        grant_nxt     = '0;
        grant_idx_nxt = '0;
        grant_val_nxt = 1'b0;
        cnt_nxt       = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so each register
    // sees the values from before this edge no matter what order the
    // statements are in.
    if (reset) begin
      // Reset wins over everything. It also drops a live grant with no
      // timeout pulse, because timeout is cleared here as well.
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      grant     <= '0;
      grant_idx <= '0;
      grant_val <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      grant     <= grant_nxt;
      grant_idx <= grant_idx_nxt;
      grant_val <= grant_val_nxt;
      timeout   <= timeout_nxt;
    end
  end

  // Structural invariants of the grant outputs.
  a_grant_onehot0: assert property (@(posedge clk) disable iff (reset)
    $onehot0(grant));
  a_grant_val: assert property (@(posedge clk) disable iff (reset)
    grant_val == (|grant));
  a_grant_idx: assert property (@(posedge clk) disable iff (reset)
    grant_val |-> grant[grant_idx]);
  a_timeout_idle: assert property (@(posedge clk) disable iff (reset)
    !(timeout && grant_val));

endmodule

// File: tb/tb_rr_arb_lock.sv
// -----------------------------------------------------------------------------
// tb_rr_arb_lock
//
// Bench for rr_arb_lock with nreqs=4 and max_hold=16. Inputs change on the
// falling edge, and outputs are sampled 1 ns after the rising edge. A small
// model tracks the owner as an int (-1 = none), how many cycles it has held
// the grant, and the priority pointer. The model predicts all four outputs
// on every cycle. Directed sequences also check fixed expected values.
// -----------------------------------------------------------------------------
module tb_rr_arb_lock;

  localparam int N = 4;
  localparam int H = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         done;
  logic [N-1:0] reqs;
  logic [N-1:0] grant;
  logic [1:0]   grant_idx;
  logic         grant_val;
  logic         timeout;

  int checks = 0;
  int errors = 0;

  // Model state
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  rr_arb_lock #(.nreqs(N), .max_hold(H)) dut (
    .clk       (clk),
    .reset     (reset),
    .reqs      (reqs),
    .done      (done),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_val (grant_val),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One rising edge of the arbiter, described in terms of owners and turns.
  task automatic model_edge(input logic r, input logic [N-1:0] rq, input logic d);
    m_to = 1'b0;
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int j = (m_ptr + k) % N;
        if (m_owner < 0 && rq[j]) begin
          m_owner = j;
          m_held  = 1;
        end
      end
    end else if (d || m_held == H) begin
      m_to    = !d;
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_held  = 0;
    end else begin
      m_held++;
    end
  endtask

  // Drive the inputs for one cycle, update the model at the edge, then compare.
  task automatic step(input logic r, input logic [N-1:0] rq, input logic d);
    reset = r;
    reqs  = rq;
    done  = d;
    @(posedge clk);
    model_edge(r, rq, d);
    #1;
    check("grant", 32'(grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check("grant_idx", 32'(grant_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check("grant_val", 32'(grant_val), 32'(m_owner >= 0));
    check("timeout", 32'(timeout), 32'(m_to));
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int seq [5] = '{0, 1, 2, 3, 0};
    logic         r_r, r_d;
    logic [N-1:0] r_q;

    reset = 1'b1;
    reqs  = '0;
    done  = 1'b0;
    @(negedge clk);

    // Reset, then five idle cycles with no requests.
    step(1'b1, 4'b0000, 1'b0);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_timeout", 32'(timeout), 32'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, 1'b0);

    // 1010 with ptr=0 picks 1. After the release ptr=2, so 3 is next.
    step(1'b0, 4'b1010, 1'b0);
    check("first_grant", 32'(grant), 32'b0010);
    check("first_idx", 32'(grant_idx), 32'd1);
    step(1'b0, 4'b1010, 1'b1);
    check("done_release", 32'(grant), 32'd0);
    step(1'b0, 4'b1010, 1'b0);
    check("second_grant", 32'(grant), 32'b1000);
    check("second_idx", 32'(grant_idx), 32'd3);
    step(1'b0, 4'b1010, 1'b1);

    // All requesting: the turn goes 0,1,2,3 and wraps to 0, with a bubble between grants.
    step(1'b1, 4'b0000, 1'b0);
    for (int g = 0; g < 5; g++) begin
      step(1'b0, 4'b1111, 1'b0);
      check("rr_val", 32'(grant_val), 32'd1);
      check("rr_seq", 32'(grant_idx), 32'(seq[g]));
      step(1'b0, 4'b1111, 1'b0);
      step(1'b0, 4'b1111, 1'b1);
      check("rr_bubble", 32'(grant_val), 32'd0);
    end

    // Forced release: exactly H grant cycles, then a single timeout pulse, then ptr=3.
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0100, 1'b0);
    hi = 0;
    while (grant_val === 1'b1 && hi < 40) begin
      hi++;
      step(1'b0, 4'b0100, 1'b0);
    end
    check("hold_len", 32'(hi), 32'(H));
    check("to_pulse", 32'(timeout), 32'd1);
    step(1'b0, 4'b1100, 1'b0);
    check("to_cleared", 32'(timeout), 32'd0);
    check("to_ptr_idx", 32'(grant_idx), 32'd3);
    step(1'b0, 4'b1100, 1'b1);

    // done on the last allowed cycle is a normal release with no timeout.
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0100, 1'b0);
    for (int i = 0; i < H - 1; i++) step(1'b0, 4'b0100, 1'b0);
    check("last_cycle_val", 32'(grant_val), 32'd1);
    step(1'b0, 4'b0100, 1'b1);
    check("last_done_val", 32'(grant_val), 32'd0);
    check("last_done_to", 32'(timeout), 32'd0);

    // Owner 2 drops its request and keeps the grant anyway. After that, 0 gets its turn.
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b0001, 1'b0);
      check("hold_grant", 32'(grant), 32'b0100);
    end
    step(1'b0, 4'b0001, 1'b1);
    check("hold_release", 32'(grant), 32'd0);
    step(1'b0, 4'b0001, 1'b0);
    check("after_hold", 32'(grant), 32'b0001);
    step(1'b0, 4'b0001, 1'b1);

    // Reset during a grant clears everything with no timeout, and ptr goes back to 0.
    step(1'b0, 4'b0010, 1'b0);
    check("pre_reset_idx", 32'(grant_idx), 32'd1);
    step(1'b1, 4'b0010, 1'b0);
    check("mid_reset_grant", 32'(grant), 32'd0);
    check("mid_reset_to", 32'(timeout), 32'd0);
    step(1'b0, 4'b0011, 1'b0);
    check("post_reset_idx", 32'(grant_idx), 32'd0);
    step(1'b0, 4'b0011, 1'b1);

    // Random traffic: frequent done first, then rare done so timeouts happen.
    for (int i = 0; i < 3000; i++) begin
      r_r = ($urandom_range(0, 63) == 0);
      r_q = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
      if (i < 1500) r_d = ($urandom_range(0, 3) == 0);
      else          r_d = ($urandom_range(0, 31) == 0);
      step(r_r, r_q, r_d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
